// File: rtl/fc_result_reader.sv
// fc_result_reader: scans the FC output buffer one word per cycle and reports
// the argmax class index and its signed score with a one-cycle done pulse.
module fc_result_reader #(
  parameter int unsigned NUM_CLASS = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned IDX_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             rd_en,
  output logic [15:0]      rd_addr,
  input  logic [15:0]      rd_data,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] class_idx,
  output logic [15:0]      max_value
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_start_q;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [IDX_W-1:0]    r_rd_idx;
  logic                r_busy;
  logic                r_done;
  logic                r_vld;
  logic [IDX_W-1:0]    r_vld_idx;
  logic [DATA_W-1:0]   r_run_max;
  logic [IDX_W-1:0]    r_run_idx;
  logic [DATA_W-1:0]   r_max_value;
  logic [IDX_W-1:0]    r_class_idx;

  logic                w_launch;
  logic                w_last_rd;
  logic                w_rd_en_nxt;
  logic [ADDR_W-1:0]   w_rd_addr_nxt;
  logic [IDX_W-1:0]    w_rd_idx_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_take;
  logic [DATA_W-1:0]   w_run_max_nxt;
  logic [IDX_W-1:0]    w_run_idx_nxt;

  // A rising start seen while idle launches exactly one scan
  assign w_launch  = start & ~r_start_q & (r_state == S_IDLE);
  assign w_last_rd = (r_rd_idx == IDX_W'(NUM_CLASS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_launch)  w_state_nxt = S_READ;
      S_READ:  if (w_last_rd) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state so every port leaves a flop
  always_comb begin
    w_rd_en_nxt   = 1'b0;
    w_rd_addr_nxt = '0;
    w_rd_idx_nxt  = '0;
    w_busy_nxt    = (w_state_nxt != S_IDLE);
    w_done_nxt    = (w_state_nxt == S_DONE);
    if (w_state_nxt == S_READ) begin
      w_rd_en_nxt = 1'b1;
      if (r_state == S_READ) begin
        w_rd_addr_nxt = r_rd_addr + ADDR_W'(1);
        w_rd_idx_nxt  = r_rd_idx + IDX_W'(1);
      end else begin
        w_rd_addr_nxt = ADDR_W'(BASE_ADDR);
        w_rd_idx_nxt  = '0;
      end
    end
  end

  // Running argmax: word 0 loads unconditionally, later words need strictly greater
  always_comb begin
    w_take        = r_vld & ((r_vld_idx == '0) | ($signed(rd_data) > $signed(r_run_max)));
    w_run_max_nxt = w_take ? rd_data   : r_run_max;
    w_run_idx_nxt = w_take ? r_vld_idx : r_run_idx;
  end

  // Output, read-pipeline and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_q   <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_idx    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_vld       <= 1'b0;
      r_vld_idx   <= '0;
      r_run_max   <= '0;
      r_run_idx   <= '0;
      r_max_value <= '0;
      r_class_idx <= '0;
    end else begin
      r_start_q <= start;
      r_rd_en   <= w_rd_en_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_rd_idx  <= w_rd_idx_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_vld     <= r_rd_en;
      r_vld_idx <= r_rd_idx;
      r_run_max <= w_run_max_nxt;
      r_run_idx <= w_run_idx_nxt;
      if (r_state == S_DRAIN) begin
        r_max_value <= w_run_max_nxt;
        r_class_idx <= w_run_idx_nxt;
      end
    end
  end

  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign class_idx = r_class_idx;
  assign max_value = r_max_value;

endmodule

// File: tb/tb_fc_result_reader.sv
// Bench for fc_result_reader: directed scenarios plus random buffers, checked
// against an argmax reference computed straight from the buffer contents.
module tb_fc_result_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start_a, start_b;
  logic        rd_en_a, rd_en_b, busy_a, busy_b, done_a, done_b;
  logic [15:0] rd_addr_a, rd_addr_b, rd_data_a, rd_data_b, max_a, max_b;
  logic [3:0]  idx_a;
  logic [1:0]  idx_b;

  fc_result_reader u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .busy(busy_a), .done(done_a), .class_idx(idx_a), .max_value(max_a)
  );

  fc_result_reader #(.NUM_CLASS(3), .BASE_ADDR(32'h20), .IDX_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .busy(busy_b), .done(done_b), .class_idx(idx_b), .max_value(max_b)
  );

  // Shared buffer with one synchronous read port per reader
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= mem[rd_addr_a];
    if (rd_en_b) rd_data_b <= mem[rd_addr_b];
  end

  int          sel = 0;
  logic        m_rd_en, m_busy, m_done;
  logic [15:0] m_rd_addr, m_max;
  logic [3:0]  m_idx;
  always_comb begin
    if (sel == 0) begin
      m_rd_en = rd_en_a; m_busy = busy_a; m_done = done_a;
      m_rd_addr = rd_addr_a; m_max = max_a; m_idx = idx_a;
    end else begin
      m_rd_en = rd_en_b; m_busy = busy_b; m_done = done_b;
      m_rd_addr = rd_addr_b; m_max = max_b; m_idx = {2'b00, idx_b};
    end
  end

  int          n_chk = 0;
  int          n_pass = 0;
  int          prev_idx [2];
  logic [15:0] prev_max [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) start_a = v;
    else          start_b = v;
  endtask

  // Reference: first occurrence of the largest signed value in the scanned window
  task automatic model(input int nc, input int base, output int eidx, output logic [15:0] emax);
    logic [15:0] v;
    eidx = 0;
    emax = mem[16'(base)];
    for (int k = 1; k < nc; k++) begin
      v = mem[16'(base + k)];
      if ($signed(v) > $signed(emax)) begin
        emax = v;
        eidx = k;
      end
    end
  endtask

  // Caller has start high in cycle T; checks cycles T+1 .. T+nc+3
  task automatic check_scan(input int nc, input int base, input int reedge_at, input string tag);
    int          eidx;
    logic [15:0] emax;
    model(nc, base, eidx, emax);
    for (int c = 1; c <= nc + 2; c++) begin
      step();
      chk($sformatf("%s rd_en c%0d", tag, c), 32'(m_rd_en), 32'(c <= nc));
      if (c <= nc) chk($sformatf("%s rd_addr c%0d", tag, c), 32'(m_rd_addr), 32'(16'(base + c - 1)));
      chk($sformatf("%s busy c%0d", tag, c), 32'(m_busy), 32'd1);
      chk($sformatf("%s done c%0d", tag, c), 32'(m_done), 32'(c == nc + 2));
      if (c == nc + 2) begin
        chk($sformatf("%s class_idx", tag), 32'(m_idx), 32'(eidx));
        chk($sformatf("%s max_value", tag), 32'(m_max), 32'(emax));
      end else begin
        chk($sformatf("%s idx held c%0d", tag, c), 32'(m_idx), 32'(prev_idx[sel]));
        chk($sformatf("%s max held c%0d", tag, c), 32'(m_max), 32'(prev_max[sel]));
      end
      if (reedge_at > 0 && c == reedge_at - 2) set_start(1'b0);
      if (reedge_at > 0 && c == reedge_at)     set_start(1'b1);
    end
    prev_idx[sel] = eidx;
    prev_max[sel] = emax;
    step();
    chk($sformatf("%s idle done", tag), 32'(m_done), 32'd0);
    chk($sformatf("%s idle busy", tag), 32'(m_busy), 32'd0);
    chk($sformatf("%s idle idx", tag), 32'(m_idx), 32'(eidx));
    chk($sformatf("%s idle max", tag), 32'(m_max), 32'(emax));
  endtask

  task automatic scan(input int nc, input int base, input int reedge_at, input string tag);
    set_start(1'b1);
    check_scan(nc, base, reedge_at, tag);
    set_start(1'b0);
    step();
  endtask

  task automatic load_rand(input int nc, input int base, input bit ties);
    for (int k = 0; k < nc; k++)
      mem[16'(base + k)] = ties ? (16'($urandom_range(0, 8)) - 16'd4) : 16'($urandom);
  endtask

  task automatic load10(input logic [15:0] v [10]);
    for (int k = 0; k < 10; k++) mem[16'(k)] = v[k];
  endtask

  logic [15:0] vec [10];

  initial begin
    reset = 1'b1; start_a = 1'b1; start_b = 1'b0;
    prev_idx[0] = 0; prev_idx[1] = 0; prev_max[0] = '0; prev_max[1] = '0;
    load_rand(10, 0, 1'b0);
    load_rand(3, 32'h20, 1'b0);

    // Reset with start held high: everything zero
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst rd_en", 32'(rd_en_a), 32'd0);
      chk("rst rd_addr", 32'(rd_addr_a), 32'd0);
      chk("rst busy", 32'(busy_a), 32'd0);
      chk("rst done", 32'(done_a), 32'd0);
      chk("rst idx", 32'(idx_a), 32'd0);
      chk("rst max", 32'(max_a), 32'd0);
    end
    // Release with start already high counts as an edge
    reset = 1'b0;
    check_scan(10, 0, 0, "rst_rel");
    for (int c = 0; c < 20; c++) begin
      step();
      chk("held no relaunch busy", 32'(busy_a), 32'd0);
    end
    start_a = 1'b0;
    step();

    vec = '{16'h0005, 16'hFFFD, 16'h0064, 16'h0007, 16'h0000,
            16'h0063, 16'hFF38, 16'h0064, 16'h0001, 16'h0002};
    load10(vec);
    scan(10, 0, 0, "basic");

    vec = '{16'hFFF7, 16'hFFFC, 16'h8000, 16'hFFFC, 16'hFFF9,
            16'hFFFB, 16'hFFFA, 16'hFFF8, 16'hFFF6, 16'hFFF5};
    load10(vec);
    scan(10, 0, 0, "allneg");

    // Extremes with start held high for 40 cycles
    for (int k = 0; k < 9; k++) mem[16'(k)] = 16'h8000;
    mem[16'd9] = 16'h7FFF;
    start_a = 1'b1;
    check_scan(10, 0, 0, "extreme");
    for (int c = 0; c < 27; c++) begin
      step();
      chk("extreme held done", 32'(done_a), 32'd0);
      chk("extreme held busy", 32'(busy_a), 32'd0);
    end
    start_a = 1'b0;
    step();

    // Second edge at T+5 is ignored
    load_rand(10, 0, 1'b1);
    scan(10, 0, 5, "busy_edge");

    // Reset abort at T+6
    load_rand(10, 0, 1'b0);
    start_a = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk("abort busy pre", 32'(busy_a), 32'd1);
    end
    reset = 1'b1;
    start_a = 1'b0;
    step();
    chk("abort rd_en", 32'(rd_en_a), 32'd0);
    chk("abort busy", 32'(busy_a), 32'd0);
    chk("abort done", 32'(done_a), 32'd0);
    chk("abort idx", 32'(idx_a), 32'd0);
    chk("abort max", 32'(max_a), 32'd0);
    prev_idx[0] = 0; prev_idx[1] = 0; prev_max[0] = '0; prev_max[1] = '0;
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      step();
      chk("abort no done", 32'(done_a), 32'd0);
    end

    // Random buffers, alternating wide and tie-heavy values
    for (int r = 0; r < 8; r++) begin
      load_rand(10, 0, r[0]);
      scan(10, 0, 0, $sformatf("rand%0d", r));
    end

    // Offset base, three classes
    sel = 1;
    mem[16'h20] = 16'd1; mem[16'h21] = 16'd3; mem[16'h22] = 16'd2;
    scan(3, 32'h20, 0, "base20");
    for (int r = 0; r < 6; r++) begin
      load_rand(3, 32'h20, r[0]);
      scan(3, 32'h20, 0, $sformatf("b_rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
